// File: rtl/operand_collector.sv
// Requesting side of the register-file read protocol: four collector slots that
// issue one RF read each, gather the returned operands and dispatch round-robin.
module operand_collector #(
  parameter int NUM_OC = 4,
  parameter int OCID_W = 2,
  parameter int ROW_W  = 3,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ROW_W-1:0]  issue_rowid_a,
  input  logic [ROW_W-1:0]  issue_rowid_b,
  input  logic              issue_two_op,
  input  logic [TAG_W-1:0]  issue_tag,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ROW_W-1:0]  req_rowid_a,
  output logic [ROW_W-1:0]  req_rowid_b,
  output logic [OCID_W-1:0] req_ocid,
  output logic              req_2op_en,
  input  logic              rsp_valid,
  input  logic [OCID_W-1:0] rsp_ocid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [DATA_W-1:0] disp_op_a,
  output logic [DATA_W-1:0] disp_op_b,
  output logic [TAG_W-1:0]  disp_tag,
  output logic [OCID_W-1:0] disp_ocid,
  output logic              err_sticky
);

  typedef enum logic [1:0] {S_FREE, S_REQ, S_WAIT, S_READY} slot_state_t;

  slot_state_t       st_q     [NUM_OC];
  slot_state_t       st_d     [NUM_OC];
  logic [ROW_W-1:0]  row_a_q  [NUM_OC];
  logic [ROW_W-1:0]  row_a_d  [NUM_OC];
  logic [ROW_W-1:0]  row_b_q  [NUM_OC];
  logic [ROW_W-1:0]  row_b_d  [NUM_OC];
  logic [TAG_W-1:0]  tag_q    [NUM_OC];
  logic [TAG_W-1:0]  tag_d    [NUM_OC];
  logic [DATA_W-1:0] op_a_q   [NUM_OC];
  logic [DATA_W-1:0] op_a_d   [NUM_OC];
  logic [DATA_W-1:0] op_b_q   [NUM_OC];
  logic [DATA_W-1:0] op_b_d   [NUM_OC];
  logic [NUM_OC-1:0] two_op_q, two_op_d;
  logic [NUM_OC-1:0] got_a_q, got_a_d;
  logic [OCID_W-1:0] rr_q, rr_d;
  logic              err_d;

  logic              issue_fire, req_fire, disp_fire;
  logic              alloc_found;
  logic [OCID_W-1:0] alloc_idx;
  logic              rsp_legal;

  logic              req_found;
  logic [OCID_W-1:0] req_sel;
  logic              disp_found;
  logic [OCID_W-1:0] disp_sel;
  logic [OCID_W-1:0] probe;

  logic              req_valid_d;
  logic [ROW_W-1:0]  req_rowid_a_d, req_rowid_b_d;
  logic [OCID_W-1:0] req_ocid_d;
  logic              req_2op_en_d;
  logic              disp_valid_d;
  logic [DATA_W-1:0] disp_op_a_d, disp_op_b_d;
  logic [TAG_W-1:0]  disp_tag_d;
  logic [OCID_W-1:0] disp_ocid_d;

  // Allocation: lowest-index FREE slot, from registered state only.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int unsigned i = 0; i < NUM_OC; i++) begin
      if (!alloc_found && st_q[i] == S_FREE) begin
        alloc_found = 1'b1;
        alloc_idx   = OCID_W'(i);
      end
    end
  end

  assign issue_ready = alloc_found;
  assign issue_fire  = issue_valid & issue_ready;
  assign req_fire    = req_valid & req_ready;
  assign disp_fire   = disp_valid & disp_ready;

  // Slot next-state: issue, request handshake, operand capture and dispatch
  // each touch a different slot or combine on the same slot in one cycle.
  always_comb begin
    for (int unsigned i = 0; i < NUM_OC; i++) begin
      st_d[i]    = st_q[i];
      row_a_d[i] = row_a_q[i];
      row_b_d[i] = row_b_q[i];
      tag_d[i]   = tag_q[i];
      op_a_d[i]  = op_a_q[i];
      op_b_d[i]  = op_b_q[i];
    end
    two_op_d  = two_op_q;
    got_a_d   = got_a_q;
    err_d     = err_sticky;
    rsp_legal = 1'b0;

    for (int unsigned i = 0; i < NUM_OC; i++) begin
      case (st_q[i])
        S_FREE: begin
          if (issue_fire && alloc_idx == OCID_W'(i)) begin
            st_d[i]     = S_REQ;
            row_a_d[i]  = issue_rowid_a;
            row_b_d[i]  = issue_rowid_b;
            tag_d[i]    = issue_tag;
            two_op_d[i] = issue_two_op;
            got_a_d[i]  = 1'b0;
            op_a_d[i]   = '0;
            op_b_d[i]   = '0;
          end
        end
        S_REQ: begin
          if (req_fire && req_ocid == OCID_W'(i)) st_d[i] = S_WAIT;
        end
        S_READY: begin
          if (disp_fire && disp_ocid == OCID_W'(i)) st_d[i] = S_FREE;
        end
        default: ;
      endcase

      if (rsp_valid && rsp_ocid == OCID_W'(i)) begin
        rsp_legal = (st_q[i] == S_WAIT) ||
                    (st_q[i] == S_REQ && req_fire && req_ocid == OCID_W'(i));
        if (!rsp_legal) begin
          err_d = 1'b1;
        end else if (!got_a_q[i]) begin
          op_a_d[i]  = rsp_data;
          got_a_d[i] = 1'b1;
          if (!two_op_q[i]) st_d[i] = S_READY;
        end else if (two_op_q[i]) begin
          op_b_d[i] = rsp_data;
          st_d[i]   = S_READY;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    rr_d = disp_fire ? disp_ocid + 1'b1 : rr_q;
  end

  // Output registers load from next-state so req/disp appear one cycle after
  // the enabling issue/capture, and hold while the consumer stalls.
  always_comb begin
    req_found = 1'b0;
    req_sel   = '0;
    for (int unsigned i = 0; i < NUM_OC; i++) begin
      if (!req_found && st_d[i] == S_REQ) begin
        req_found = 1'b1;
        req_sel   = OCID_W'(i);
      end
    end

    disp_found = 1'b0;
    disp_sel   = '0;
    probe      = '0;
    for (int unsigned k = 0; k < NUM_OC; k++) begin
      probe = rr_d + OCID_W'(k);
      if (!disp_found && st_d[probe] == S_READY) begin
        disp_found = 1'b1;
        disp_sel   = probe;
      end
    end

    req_valid_d   = req_valid;
    req_rowid_a_d = req_rowid_a;
    req_rowid_b_d = req_rowid_b;
    req_ocid_d    = req_ocid;
    req_2op_en_d  = req_2op_en;
    if (!req_valid || req_ready) begin
      req_valid_d   = req_found;
      req_rowid_a_d = row_a_d[req_sel];
      req_rowid_b_d = row_b_d[req_sel];
      req_ocid_d    = req_sel;
      req_2op_en_d  = two_op_d[req_sel];
    end

    disp_valid_d = disp_valid;
    disp_op_a_d  = disp_op_a;
    disp_op_b_d  = disp_op_b;
    disp_tag_d   = disp_tag;
    disp_ocid_d  = disp_ocid;
    if (!disp_valid || disp_ready) begin
      disp_valid_d = disp_found;
      disp_op_a_d  = op_a_d[disp_sel];
      disp_op_b_d  = two_op_d[disp_sel] ? op_b_d[disp_sel] : '0;
      disp_tag_d   = tag_d[disp_sel];
      disp_ocid_d  = disp_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_OC; i++) begin
        st_q[i]    <= S_FREE;
        row_a_q[i] <= '0;
        row_b_q[i] <= '0;
        tag_q[i]   <= '0;
        op_a_q[i]  <= '0;
        op_b_q[i]  <= '0;
      end
      two_op_q    <= '0;
      got_a_q     <= '0;
      rr_q        <= '0;
      err_sticky  <= 1'b0;
      req_valid   <= 1'b0;
      req_rowid_a <= '0;
      req_rowid_b <= '0;
      req_ocid    <= '0;
      req_2op_en  <= 1'b0;
      disp_valid  <= 1'b0;
      disp_op_a   <= '0;
      disp_op_b   <= '0;
      disp_tag    <= '0;
      disp_ocid   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_OC; i++) begin
        st_q[i]    <= st_d[i];
        row_a_q[i] <= row_a_d[i];
        row_b_q[i] <= row_b_d[i];
        tag_q[i]   <= tag_d[i];
        op_a_q[i]  <= op_a_d[i];
        op_b_q[i]  <= op_b_d[i];
      end
      two_op_q    <= two_op_d;
      got_a_q     <= got_a_d;
      rr_q        <= rr_d;
      err_sticky  <= err_d;
      req_valid   <= req_valid_d;
      req_rowid_a <= req_rowid_a_d;
      req_rowid_b <= req_rowid_b_d;
      req_ocid    <= req_ocid_d;
      req_2op_en  <= req_2op_en_d;
      disp_valid  <= disp_valid_d;
      disp_op_a   <= disp_op_a_d;
      disp_op_b   <= disp_op_b_d;
      disp_tag    <= disp_tag_d;
      disp_ocid   <= disp_ocid_d;
    end
  end

endmodule
